// File: rtl/cache_line_fill_responder.sv
// Memory-side responder for data-cache line fills: acknowledges a request, reads the line
// word by word (lowest address first), streams each word back, then holds line-valid until done.
module cache_line_fill_responder #(
    parameter int PORT_WIDTH  = 32,
    parameter int BLOCK_WIDTH = 128,
    parameter int XLEN        = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  processor_request_i,
    input  logic [XLEN-1:0]       request_address_i,
    input  logic                  done_i,
    output logic                  external_acknowledge_o,
    output logic [PORT_WIDTH-1:0] external_data_o,
    output logic                  external_data_valid_o,
    output logic                  cache_line_valid_o,
    output logic                  mem_read_o,
    output logic [XLEN-1:0]       mem_address_o,
    input  logic [PORT_WIDTH-1:0] mem_data_i,
    input  logic                  mem_ready_i,
    output logic                  idle_o
);

    localparam int WORDS  = BLOCK_WIDTH / PORT_WIDTH;
    localparam int CNT_W  = $clog2(WORDS);
    localparam int BYTE_W = $clog2(PORT_WIDTH / 8);
    localparam int OFF_W  = CNT_W + BYTE_W;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACKNOWLEDGE,
        FETCH,
        LINE_VALID
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [XLEN-OFF_W-1:0]    line_q, line_d;
    logic                     ack_q, ack_d;
    logic [PORT_WIDTH-1:0]    data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     line_valid_q, line_valid_d;
    logic                     idle_q, idle_d;

    // Offset bits within the line are discarded: only the line number is latched.
    logic unused_addr_bits;
    assign unused_addr_bits = ^request_address_i[OFF_W-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        data_d  = data_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (processor_request_i) begin
                    line_d  = request_address_i[XLEN-1:OFF_W];
                    cnt_d   = '0;
                    state_d = ACKNOWLEDGE;
                end
            end
            ACKNOWLEDGE: state_d = FETCH;
            FETCH: begin
                if (mem_ready_i) begin
                    data_d  = mem_data_i;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_WORD) begin
                        state_d = LINE_VALID;
                    end
                end
            end
            LINE_VALID: begin
                if (done_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ack_d = (state_d == ACKNOWLEDGE);
        // Line-valid lags entry into LINE_VALID by one cycle so it never overlaps the last strobe.
        line_valid_d = (state_q == LINE_VALID) && !done_i;
        idle_d       = (state_d == IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            line_q       <= '0;
            ack_q        <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            line_valid_q <= 1'b0;
            idle_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            line_q       <= line_d;
            ack_q        <= ack_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            line_valid_q <= line_valid_d;
            idle_q       <= idle_d;
        end
    end

    // Address is a pure concatenation of registers, so it carries no adder glitches.
    always_comb begin
        mem_address_o                   = '0;
        mem_address_o[XLEN-1:OFF_W]     = line_q;
        mem_address_o[OFF_W-1:BYTE_W]   = cnt_q;
    end

    assign mem_read_o             = (state_q == FETCH);
    assign external_acknowledge_o = ack_q;
    assign external_data_o        = data_q;
    assign external_data_valid_o  = valid_q;
    assign cache_line_valid_o     = line_valid_q;
    assign idle_o                 = idle_q;

endmodule

// File: tb/tb_cache_line_fill_responder.sv
// Self-checking bench for cache_line_fill_responder: cycle-accurate expectations per fill
// plus a scoreboard queue of expected returned words.
module tb_cache_line_fill_responder;

    localparam int WORDS = 4;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        processor_request_i;
    logic [31:0] request_address_i;
    logic        done_i;
    logic        external_acknowledge_o;
    logic [31:0] external_data_o;
    logic        external_data_valid_o;
    logic        cache_line_valid_o;
    logic        mem_read_o;
    logic [31:0] mem_address_o;
    logic [31:0] mem_data_i;
    logic        mem_ready_i;
    logic        idle_o;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_word;

    int          wait_n      = 0;
    int          wcnt        = 0;
    logic        force_ready = 1'b0;

    cache_line_fill_responder #(
        .PORT_WIDTH (32),
        .BLOCK_WIDTH(128),
        .XLEN       (32)
    ) dut (
        .clk_i                 (clk_i),
        .rst_n_i               (rst_n_i),
        .processor_request_i   (processor_request_i),
        .request_address_i     (request_address_i),
        .done_i                (done_i),
        .external_acknowledge_o(external_acknowledge_o),
        .external_data_o       (external_data_o),
        .external_data_valid_o (external_data_valid_o),
        .cache_line_valid_o    (cache_line_valid_o),
        .mem_read_o            (mem_read_o),
        .mem_address_o         (mem_address_o),
        .mem_data_i            (mem_data_i),
        .mem_ready_i           (mem_ready_i),
        .idle_o                (idle_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory model: address-tagged data, ready after wait_n stalled cycles of each read.
    assign mem_data_i  = 32'hD000_0000 ^ mem_address_o;
    assign mem_ready_i = force_ready | (mem_read_o & (wcnt >= wait_n));

    always @(posedge clk_i) begin
        if (mem_read_o !== 1'b1 || mem_ready_i) wcnt <= 0;
        else                                    wcnt <= wcnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (external_data_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL strobe_unexpected: got data %h expected no strobe", external_data_o);
            end else begin
                exp_word = exp_q.pop_front();
                chk("strobe_data", external_data_o, exp_word);
                chk("strobe_not_with_line_valid", {31'd0, cache_line_valid_o}, 32'd0);
            end
        end
    end

    // Entered at a negedge in IDLE; returns at the negedge of the first cycle back in IDLE.
    task automatic run_fill(input logic [31:0] addr, input logic [31:0] base,
                            input int w, input int d, input bit keep);
        int p, l, last, idx;
        bit ack_e, rd_e, st_e, lv_e, idle_e;
        p    = w + 1;
        l    = 3 + WORDS * p;
        last = l + d;
        wait_n = w;
        chk("entry_idle", {31'd0, idle_o}, 32'd1);
        processor_request_i = 1'b1;
        request_address_i   = addr;
        for (int i = 0; i < WORDS; i++) exp_q.push_back(32'hD000_0000 ^ (base + 32'(i * 4)));
        for (int k = 1; k <= last; k++) begin
            @(negedge clk_i);
            ack_e  = (k == 1);
            rd_e   = (k >= 2) && (k <= 1 + WORDS * p);
            st_e   = (k >= 3 + w) && (((k - 3 - w) % p) == 0) && (((k - 3 - w) / p) < WORDS);
            lv_e   = (k >= l) && (k < last);
            idle_e = (k == last);
            chk($sformatf("ack k=%0d", k),        {31'd0, external_acknowledge_o}, {31'd0, ack_e});
            chk($sformatf("mem_read k=%0d", k),   {31'd0, mem_read_o},             {31'd0, rd_e});
            chk($sformatf("strobe k=%0d", k),     {31'd0, external_data_valid_o},  {31'd0, st_e});
            chk($sformatf("line_valid k=%0d", k), {31'd0, cache_line_valid_o},     {31'd0, lv_e});
            chk($sformatf("idle k=%0d", k),       {31'd0, idle_o},                 {31'd0, idle_e});
            if (rd_e) begin
                idx = (k - 2) / p;
                chk($sformatf("mem_address k=%0d", k), mem_address_o, base + 32'(idx * 4));
            end
            if (k == 1 && !keep) processor_request_i = 1'b0;
            if (k == last - 1)   done_i = 1'b1;
            if (k == last)       done_i = 1'b0;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] base;
        int          waitn;
        int          doned;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{addr: 32'h0000_1234, base: 32'h0000_1230, waitn: 0, doned: 1};
        vecs[1] = '{addr: 32'h0000_1234, base: 32'h0000_1230, waitn: 2, doned: 1};
        vecs[2] = '{addr: 32'hABCD_EF0F, base: 32'hABCD_EF00, waitn: 1, doned: 10};
        vecs[3] = '{addr: 32'hFFFF_FFFF, base: 32'hFFFF_FFF0, waitn: 0, doned: 3};

        rst_n_i             = 1'b0;
        processor_request_i = 1'b1;
        request_address_i   = 32'h0000_1234;
        done_i              = 1'b0;
        force_ready         = 1'b1;
        @(posedge clk_i);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            chk("rst_ack",        {31'd0, external_acknowledge_o}, 32'd0);
            chk("rst_data",       external_data_o,                 32'd0);
            chk("rst_strobe",     {31'd0, external_data_valid_o},  32'd0);
            chk("rst_line_valid", {31'd0, cache_line_valid_o},     32'd0);
            chk("rst_mem_read",   {31'd0, mem_read_o},             32'd0);
            chk("rst_mem_addr",   mem_address_o,                   32'd0);
            chk("rst_idle",       {31'd0, idle_o},                 32'd1);
        end
        processor_request_i = 1'b0;
        force_ready         = 1'b0;
        rst_n_i             = 1'b1;
        @(negedge clk_i);
        chk("post_rst_idle", {31'd0, idle_o}, 32'd1);
        chk("post_rst_ack",  {31'd0, external_acknowledge_o}, 32'd0);

        for (int v = 0; v < 4; v++) begin
            run_fill(vecs[v].addr, vecs[v].base, vecs[v].waitn, vecs[v].doned, 1'b0);
            @(negedge clk_i);
        end

        // Back-to-back: request held through the whole first fill and its done.
        run_fill(32'h0000_0040, 32'h0000_0040, 0, 2, 1'b1);
        run_fill(32'h0000_5008, 32'h0000_5000, 0, 1, 1'b0);
        @(negedge clk_i);
        chk("b2b_stays_idle", {31'd0, idle_o}, 32'd1);

        // Reset after the second word: no further strobes, then a clean restart.
        wait_n              = 0;
        processor_request_i = 1'b1;
        request_address_i   = 32'h0000_2048;
        exp_q.push_back(32'hD000_0000 ^ 32'h0000_2040);
        exp_q.push_back(32'hD000_0000 ^ 32'h0000_2044);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_i);
            if (k == 1) processor_request_i = 1'b0;
        end
        chk("abort_second_strobe", {31'd0, external_data_valid_o}, 32'd1);
        rst_n_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            chk("abort_strobe",   {31'd0, external_data_valid_o}, 32'd0);
            chk("abort_mem_read", {31'd0, mem_read_o},            32'd0);
            chk("abort_mem_addr", mem_address_o,                  32'd0);
            chk("abort_idle",     {31'd0, idle_o},                32'd1);
        end
        rst_n_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            chk("abort_quiet", {31'd0, external_data_valid_o}, 32'd0);
        end
        chk("abort_queue_drained", 32'(exp_q.size()), 32'd0);
        run_fill(32'h0000_2048, 32'h0000_2040, 0, 1, 1'b0);

        repeat (2) @(negedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
